// File: rtl/mpu_switch_debounce.sv
`default_nettype none
// ============================================================================
// mpu_switch_debounce : front-panel run/stop and single-step conditioner
// Revision 1.0 - initial release
// ============================================================================
module mpu_switch_debounce #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int CNT_W           = 19,
    parameter bit ACTIVE_LOW      = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic sw_en_raw,
    input  logic btn_step_raw,
    output logic clk_en,
    output logic single_step
);

    localparam logic [CNT_W-1:0] CNT_TERM = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    // Bit 0 is the run/stop switch, bit 1 the single-step button.
    logic [1:0] raw_act;
    logic [1:0] sync_meta;
    logic [1:0] sync_out;

    logic             sw_db;
    logic [CNT_W-1:0] sw_cnt;
    logic             btn_db;
    logic [CNT_W-1:0] btn_cnt;

    assign raw_act = {btn_step_raw, sw_en_raw} ^ {2{ACTIVE_LOW}};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_meta <= 2'b00;
            sync_out  <= 2'b00;
        end else begin
            sync_meta <= raw_act;
            sync_out  <= sync_meta;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sw_db  <= 1'b0;
            sw_cnt <= '0;
        end else if (sync_out[0] == sw_db) begin
            sw_cnt <= '0;
        end else if (sw_cnt == CNT_TERM) begin
            sw_db  <= sync_out[0];
            sw_cnt <= '0;
        end else begin
            sw_cnt <= sw_cnt + CNT_ONE;
        end
    end

    // The pulse is registered on the very edge that commits a 0->1 change.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            btn_db      <= 1'b0;
            btn_cnt     <= '0;
            single_step <= 1'b0;
        end else begin
            single_step <= 1'b0;
            if (sync_out[1] == btn_db) begin
                btn_cnt <= '0;
            end else if (btn_cnt == CNT_TERM) begin
                btn_db      <= sync_out[1];
                btn_cnt     <= '0;
                single_step <= sync_out[1];
            end else begin
                btn_cnt <= btn_cnt + CNT_ONE;
            end
        end
    end

    assign clk_en = sw_db;

endmodule
`default_nettype wire

// File: tb/tb_mpu_switch_debounce.sv
`default_nettype none
// Bench for mpu_switch_debounce: vector table, directed corner cases and
// randomized stimulus checked against a sliding-window reference model.
module tb_mpu_switch_debounce;

    localparam int N  = 8;
    localparam bit AL = 1'b1;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic sw_en_raw = 1'b1;
    logic btn_step_raw = 1'b1;
    logic clk_en;
    logic single_step;

    mpu_switch_debounce #(
        .DEBOUNCE_CYCLES(N),
        .CNT_W(4),
        .ACTIVE_LOW(AL)
    ) dut (
        .clk(clk),
        .rst(rst),
        .sw_en_raw(sw_en_raw),
        .btn_step_raw(btn_step_raw),
        .clk_en(clk_en),
        .single_step(single_step)
    );

    always #10 clk = ~clk;

    int n_cmp = 0;
    int n_fail = 0;
    int cyc = 0;
    int pulse_cnt = 0;
    int pulse_cyc[$];

    // Reference model: the debounced level follows the synchronised input
    // once the last N samples since the previous change all disagree with it.
    bit [1:0] m_meta, m_sync, m_db;
    bit       m_pulse;
    bit       win [0:1][0:N-1];
    int       fill [0:1];

    task automatic check(string name, logic [31:0] got, logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, got, exp);
        end
    endtask

    function automatic void model_clear();
        m_meta = '0; m_sync = '0; m_db = '0; m_pulse = 1'b0;
        for (int c = 0; c < 2; c++) fill[c] = 0;
    endfunction

    function automatic void model_edge();
        bit [1:0] s;
        bit all_diff;
        s = m_sync;
        m_pulse = 1'b0;
        for (int c = 0; c < 2; c++) begin
            for (int i = N - 1; i > 0; i--) win[c][i] = win[c][i-1];
            win[c][0] = s[c];
            if (fill[c] < N) fill[c]++;
            all_diff = 1'b1;
            for (int i = 0; i < N; i++) if (win[c][i] == m_db[c]) all_diff = 1'b0;
            if (fill[c] == N && all_diff) begin
                m_db[c] = s[c];
                fill[c] = 0;
                if (c == 1 && s[c]) m_pulse = 1'b1;
            end
        end
        m_sync = m_meta;
        m_meta = {btn_step_raw ^ AL, sw_en_raw ^ AL};
    endfunction

    task automatic tick();
        @(posedge clk);
        if (rst) model_edge();
        else model_clear();
        #1;
        cyc++;
        if (single_step === 1'b1) begin
            pulse_cnt++;
            pulse_cyc.push_back(cyc);
        end
        check("model_clk_en", {31'd0, clk_en}, {31'd0, m_db[0]});
        check("model_single_step", {31'd0, single_step}, {31'd0, m_pulse});
    endtask

    task automatic ticks(int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic async_reset();
        rst = 1'b0;
        #1;
        model_clear();
        check("async_rst_clk_en", {31'd0, clk_en}, 32'd0);
        check("async_rst_single_step", {31'd0, single_step}, 32'd0);
    endtask

    typedef struct {
        bit sw;
        bit btn;
        int cycles;
        bit exp_clk_en;
        int exp_pulses;
    } vec_t;

    vec_t tbl [10];

    initial begin
        int p0;

        // Raw inputs in the table are electrical levels: 0 = asserted.
        tbl[0] = '{1'b0, 1'b1, 12, 1'b1, 0};
        tbl[1] = '{1'b0, 1'b0, 12, 1'b1, 1};
        tbl[2] = '{1'b0, 1'b0, 20, 1'b1, 0};
        tbl[3] = '{1'b1, 1'b1,  9, 1'b1, 0};
        tbl[4] = '{1'b1, 1'b1,  1, 1'b0, 0};
        tbl[5] = '{1'b0, 1'b0,  5, 1'b0, 0};
        tbl[6] = '{1'b1, 1'b1,  5, 1'b0, 0};
        tbl[7] = '{1'b0, 1'b1, 10, 1'b1, 0};
        tbl[8] = '{1'b1, 1'b0, 10, 1'b0, 1};
        tbl[9] = '{1'b1, 1'b1, 15, 1'b0, 0};

        model_clear();

        // Reset held with both inputs asserted, then release.
        sw_en_raw = 1'b0; btn_step_raw = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("rst_clk_en", {31'd0, clk_en}, 32'd0);
            check("rst_single_step", {31'd0, single_step}, 32'd0);
        end
        rst = 1'b1;
        ticks(9);
        check("rel_clk_en_early", {31'd0, clk_en}, 32'd0);
        tick();
        check("rel_clk_en_10", {31'd0, clk_en}, 32'd1);
        check("rel_step_10", {31'd0, single_step}, 32'd1);
        tick();
        check("rel_step_width", {31'd0, single_step}, 32'd0);

        // Release both inputs and let them settle.
        sw_en_raw = 1'b1; btn_step_raw = 1'b1;
        ticks(12);
        check("settle_clk_en", {31'd0, clk_en}, 32'd0);

        // Clean switch edges in both directions.
        p0 = pulse_cnt;
        sw_en_raw = 1'b0;
        ticks(9);
        check("sw_on_early", {31'd0, clk_en}, 32'd0);
        tick();
        check("sw_on_10", {31'd0, clk_en}, 32'd1);
        ticks(5);
        sw_en_raw = 1'b1;
        ticks(9);
        check("sw_off_early", {31'd0, clk_en}, 32'd1);
        tick();
        check("sw_off_10", {31'd0, clk_en}, 32'd0);
        check("sw_no_pulse", pulse_cnt - p0, 32'd0);

        // Vector table.
        for (int v = 0; v < 10; v++) begin
            sw_en_raw = tbl[v].sw; btn_step_raw = tbl[v].btn;
            p0 = pulse_cnt;
            ticks(tbl[v].cycles);
            check($sformatf("tbl%0d_clk_en", v), {31'd0, clk_en}, {31'd0, tbl[v].exp_clk_en});
            check($sformatf("tbl%0d_pulses", v), pulse_cnt - p0, tbl[v].exp_pulses);
        end

        // Bounce shorter than the debounce window never propagates.
        p0 = pulse_cnt;
        for (int i = 0; i < 40; i++) begin
            if (i % 3 == 0) btn_step_raw = ~btn_step_raw;
            tick();
        end
        btn_step_raw = 1'b1;
        ticks(15);
        check("bounce_pulses", pulse_cnt - p0, 32'd0);

        // Press and hold, then release.
        p0 = pulse_cnt;
        btn_step_raw = 1'b0;
        ticks(9);
        check("hold_step_early", {31'd0, single_step}, 32'd0);
        tick();
        check("hold_step_10", {31'd0, single_step}, 32'd1);
        tick();
        check("hold_step_width", {31'd0, single_step}, 32'd0);
        ticks(89);
        btn_step_raw = 1'b1;
        ticks(20);
        check("hold_pulses", pulse_cnt - p0, 32'd1);

        // Three clean presses, 40 cycles apart.
        p0 = pulse_cnt;
        pulse_cyc.delete();
        for (int k = 0; k < 3; k++) begin
            btn_step_raw = 1'b0; ticks(20);
            btn_step_raw = 1'b1; ticks(20);
        end
        check("rep_pulses", pulse_cnt - p0, 32'd3);
        if (pulse_cyc.size() == 3) begin
            check("rep_gap1", pulse_cyc[1] - pulse_cyc[0], 32'd40);
            check("rep_gap2", pulse_cyc[2] - pulse_cyc[1], 32'd40);
        end else begin
            check("rep_pulse_list", pulse_cyc.size(), 32'd3);
        end

        // Reset in the middle of a count, button still held on release.
        p0 = pulse_cnt;
        btn_step_raw = 1'b0;
        ticks(7);
        async_reset();
        ticks(3);
        check("midrst_no_pulse", pulse_cnt - p0, 32'd0);
        rst = 1'b1;
        ticks(9);
        check("midrst_step_early", {31'd0, single_step}, 32'd0);
        tick();
        check("midrst_step_10", {31'd0, single_step}, 32'd1);
        btn_step_raw = 1'b1;
        ticks(12);
        check("midrst_pulses", pulse_cnt - p0, 32'd1);

        // Randomized runs with occasional asynchronous resets.
        for (int seg = 0; seg < 300; seg++) begin
            sw_en_raw = 1'($urandom);
            btn_step_raw = 1'($urandom);
            if ($urandom_range(0, 49) == 0) begin
                async_reset();
                ticks($urandom_range(1, 3));
                rst = 1'b1;
            end
            ticks($urandom_range(1, 20));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mpu_switch_debounce.md
Name: mpu_switch_debounce

Overview:
Front-panel input conditioner for the 6502 MPU clock chain. Takes the raw run/stop switch and the raw single-step pushbutton, synchronises both to the 50 MHz system clock, and debounces each with a stable-time counter. It drives the debounced clk_en level and a one-clk-cycle single_step pulse directly into mpu_clock_div.

Parameters:
DEBOUNCE_CYCLES, 500000, consecutive stable clk cycles required before a debounced output changes (10 ms at 50 MHz); legal range 2..2^CNT_W.
CNT_W, 19, width of each debounce counter; must satisfy 2^CNT_W >= DEBOUNCE_CYCLES.
ACTIVE_LOW, 1, 1 = raw inputs are asserted low (board pull-ups); 0 = asserted high.

Ports:
clk  input  1  50 MHz system clock; all state updates on posedge.
rst  input  1  reset, active-low, asynchronous assert, release synchronous to clk by the top level.
sw_en_raw  input  1  raw run/stop switch, asynchronous to clk.
btn_step_raw  input  1  raw single-step pushbutton, asynchronous to clk.
clk_en  output  1  debounced run/stop level, active high; feeds mpu_clock_div clk_en.
single_step  output  1  one clk-cycle pulse per debounced button press; feeds mpu_clock_div single_step.

Behaviour:
- Reset: one clock; reset is asynchronous and active-low. While rst=0: all synchroniser flops, both debounced levels, both counters, clk_en and single_step are 0 (logical deasserted). No output glitch on release.
- Polarity: each raw input is XORed with ACTIVE_LOW before synchronisation, so the internal logic is always active-high. The synchroniser reset value is logical 0.
- Synchroniser: 2-flop chain per input. No combinational logic between the flops.
- Debounce, per channel, with registered state db and counter cnt:
  - sync == db: cnt <= 0.
  - sync != db and cnt != DEBOUNCE_CYCLES-1: cnt <= cnt+1.
  - sync != db and cnt == DEBOUNCE_CYCLES-1: db <= sync, cnt <= 0.
  - Any single cycle of agreement restarts the count, so a bounce shorter than DEBOUNCE_CYCLES never propagates.
- Latency: a clean raw edge reaches db exactly 2 + DEBOUNCE_CYCLES clk cycles later.
- clk_en = switch-channel db, registered, no further logic.
- single_step: a registered pulse asserted for exactly 1 cycle, on the same edge where the button db goes 0->1.
  - No pulse on release (1->0).
  - No repeat while the button is held.
  - Back-to-back pulses are separated by at least 2*DEBOUNCE_CYCLES cycles.
- Channels are fully independent. A simultaneous switch and button change is handled in parallel with no priority.
- Counter never wraps: the terminal compare at DEBOUNCE_CYCLES-1 always resets it.
- Reset asserted mid-count: the count is discarded and outputs go to 0 immediately (asynchronously). After release, an input held asserted reappears after 2 + DEBOUNCE_CYCLES cycles; a held button then yields one single_step pulse.

Test Plan:
(Bench uses DEBOUNCE_CYCLES=8, ACTIVE_LOW=1.)
1. Reset: hold rst=0 with sw_en_raw=0, btn_step_raw=0 (both asserted) -> clk_en=0 and single_step=0 throughout; after release, clk_en rises exactly 10 cycles later and single_step pulses once in that same cycle.
2. Clean switch: sw_en_raw 1->0 at cycle T -> clk_en=1 from cycle T+10. Then 0->1 -> clk_en=0 exactly 10 cycles later. single_step stays 0 throughout.
3. Bounce rejection: btn_step_raw toggled low/high every 3 cycles for 40 cycles, then held high -> single_step never asserts; button db stays 0.
4. Press and hold: btn_step_raw held low for 100 cycles, then released -> exactly one single_step pulse, 1 cycle wide, at press+10; no pulse on release.
5. Repeated presses: three clean presses, each 20 cycles low and 20 cycles high -> exactly three pulses, 40 cycles apart.
6. Mid-count reset: start a button press, assert rst at count 5, release rst while the button is still held -> no pulse before reset; exactly one pulse 10 cycles after rst release.
